// File: rtl/alu_arbiter_pkg.sv
// Shared constants for the two-requester ALU arbiter: data width, ALU op codes,
// FSM state encoding and an op-code legality helper.
package alu_arbiter_pkg;

  localparam int DATA_W = 32;
  localparam logic [DATA_W-1:0] DATA_ZERO = {DATA_W{1'b0}};
  localparam logic [DATA_W-1:0] DATA_ONE  = {{(DATA_W-1){1'b0}}, 1'b1};

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_NOR = 4'b1100;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_RESP = 2'b10
  } state_e;

  function automatic logic op_legal(input logic [3:0] op);
    logic ok;
    case (op)
      OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT, OP_NOR: ok = 1'b1;
      default:                                       ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/alu_arbiter_alu.sv
// Combinational 32-bit ALU shared by both requesters; unknown op codes give
// a zero result with err set.
module alu_arbiter_alu
  import alu_arbiter_pkg::*;
(
  input  logic [3:0]        ctrl,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] result,
  output logic              zero,
  output logic              err
);

  // Operation decode; SLT compares as unsigned.
  always_comb begin
    result = DATA_ZERO;
    err    = ~op_legal(ctrl);
    case (ctrl)
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_ADD:  result = a + b;
      OP_SUB:  result = a - b;
      OP_SLT:  result = (a < b) ? DATA_ONE : DATA_ZERO;
      OP_NOR:  result = ~(a | b);
      default: result = DATA_ZERO;
    endcase
    zero = (result == DATA_ZERO);
  end

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester front end for one shared ALU: IDLE -> EXEC -> RESP.
// Define ALU_ARB_RR_EN for round-robin arbitration; otherwise requester 0 wins conflicts.
module alu_arbiter
  import alu_arbiter_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  input  logic              req1_valid,
  input  logic [3:0]        req0_ctrl,
  input  logic [3:0]        req1_ctrl,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  output logic              ack0,
  output logic              ack1,
  output logic              resp0_valid,
  output logic              resp1_valid,
  output logic [DATA_W-1:0] resp_data,
  output logic              resp_zero,
  output logic              resp_err,
  output logic              busy
);

  state_e            state_r;
  logic              owner_r;
  logic [3:0]        ctrl_r;
  logic [DATA_W-1:0] a_r;
  logic [DATA_W-1:0] b_r;
`ifdef ALU_ARB_RR_EN
  logic              rr_ptr_r;
`endif

  logic              grant_s;
  logic              winner_s;
  logic [3:0]        sel_ctrl_s;
  logic [DATA_W-1:0] sel_a_s;
  logic [DATA_W-1:0] sel_b_s;
  logic [DATA_W-1:0] alu_result_s;
  logic              alu_zero_s;
  logic              alu_err_s;

  // Winner selection; requests are only looked at in IDLE and never during reset.
  always_comb begin
    grant_s  = 1'b0;
    winner_s = 1'b0;
    if ((state_r == ST_IDLE) && !rst) begin
      if (req0_valid && req1_valid) begin
        grant_s = 1'b1;
`ifdef ALU_ARB_RR_EN
        winner_s = rr_ptr_r;
`else
        winner_s = 1'b0;
`endif
      end else if (req0_valid) begin
        grant_s  = 1'b1;
        winner_s = 1'b0;
      end else if (req1_valid) begin
        grant_s  = 1'b1;
        winner_s = 1'b1;
      end else begin
        grant_s  = 1'b0;
        winner_s = 1'b0;
      end
    end else begin
      grant_s  = 1'b0;
      winner_s = 1'b0;
    end
  end

  assign ack0       = grant_s & ~winner_s;
  assign ack1       = grant_s & winner_s;
  assign sel_ctrl_s = winner_s ? req1_ctrl : req0_ctrl;
  assign sel_a_s    = winner_s ? req1_a : req0_a;
  assign sel_b_s    = winner_s ? req1_b : req0_b;

  alu_arbiter_alu u_alu (
    .ctrl   (ctrl_r),
    .a      (a_r),
    .b      (b_r),
    .result (alu_result_s),
    .zero   (alu_zero_s),
    .err    (alu_err_s)
  );

  // Control FSM with registered response outputs; result registers hold between responses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      owner_r     <= 1'b0;
      ctrl_r      <= 4'b0000;
      a_r         <= DATA_ZERO;
      b_r         <= DATA_ZERO;
      resp0_valid <= 1'b0;
      resp1_valid <= 1'b0;
      resp_data   <= DATA_ZERO;
      resp_zero   <= 1'b0;
      resp_err    <= 1'b0;
      busy        <= 1'b0;
`ifdef ALU_ARB_RR_EN
      rr_ptr_r    <= 1'b0;
`endif
    end else begin
      case (state_r)
        ST_IDLE: begin
          resp0_valid <= 1'b0;
          resp1_valid <= 1'b0;
          if (grant_s) begin
            ctrl_r   <= sel_ctrl_s;
            a_r      <= sel_a_s;
            b_r      <= sel_b_s;
            owner_r  <= winner_s;
            busy     <= 1'b1;
            state_r  <= ST_EXEC;
`ifdef ALU_ARB_RR_EN
            rr_ptr_r <= ~winner_s;
`endif
          end else begin
            busy    <= 1'b0;
            state_r <= ST_IDLE;
          end
        end
        ST_EXEC: begin
          resp_data   <= alu_result_s;
          resp_zero   <= alu_zero_s;
          resp_err    <= alu_err_s;
          resp0_valid <= ~owner_r;
          resp1_valid <= owner_r;
          busy        <= 1'b1;
          state_r     <= ST_RESP;
        end
        ST_RESP: begin
          resp0_valid <= 1'b0;
          resp1_valid <= 1'b0;
          busy        <= 1'b0;
          state_r     <= ST_IDLE;
        end
        default: begin
          resp0_valid <= 1'b0;
          resp1_valid <= 1'b0;
          busy        <= 1'b0;
          state_r     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed cases plus randomized traffic
// compared every cycle against a cycle-count based behavioural model.
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rv [2];
  logic [3:0]  rc [2];
  logic [31:0] ra [2];
  logic [31:0] rb [2];
  logic        ack0, ack1, resp0_valid, resp1_valid, resp_zero, resp_err, busy;
  logic [31:0] resp_data;

  int total = 0;
  int bad   = 0;

`ifdef ALU_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  // Model state: cycle of last accepted request and the response it owes.
  int          cyc        = 0;
  int          last_ack   = -100;
  int          pend_owner = 0;
  logic [31:0] pend_data  = 32'd0;
  logic        pend_err   = 1'b0;
  int          pref       = 0;
  logic [31:0] m_data     = 32'd0;
  logic        m_zero     = 1'b0;
  logic        m_err      = 1'b0;
  int          cur_grant  = -1;

  // Snapshot of DUT outputs from the most recent checked cycle.
  logic        s_ack0, s_ack1, s_r0, s_r1, s_zero, s_err, s_busy;
  logic [31:0] s_data;

  always #5 clk = ~clk;

  alu_arbiter dut (
    .clk(clk), .rst(rst),
    .req0_valid(rv[0]), .req1_valid(rv[1]),
    .req0_ctrl(rc[0]), .req1_ctrl(rc[1]),
    .req0_a(ra[0]), .req0_b(rb[0]), .req1_a(ra[1]), .req1_b(rb[1]),
    .ack0(ack0), .ack1(ack1),
    .resp0_valid(resp0_valid), .resp1_valid(resp1_valid),
    .resp_data(resp_data), .resp_zero(resp_zero), .resp_err(resp_err),
    .busy(busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at t=%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  function automatic void ref_op(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] d, output logic e);
    longint unsigned x, y;
    longint unsigned m;
    x = 64'(a);
    y = 64'(b);
    m = 64'h1_0000_0000;
    e = 1'b0;
    case (c)
      4'b0000: d = a & b;
      4'b0001: d = a | b;
      4'b0010: d = 32'((x + y) % m);
      4'b0110: d = 32'((x + m - y) % m);
      4'b0111: d = (x < y) ? 32'd1 : 32'd0;
      4'b1100: d = ~(a | b);
      default: begin d = 32'd0; e = 1'b1; end
    endcase
  endfunction

  // Predict this cycle's outputs from the rules, compare, then advance the model.
  task automatic check_cycle();
    logic e_r0, e_r1, e_busy;
    int w;
    int age;
    cyc++;
    age    = cyc - last_ack;
    e_busy = (age == 1) || (age == 2);
    e_r0   = 1'b0;
    e_r1   = 1'b0;
    if (age == 2) begin
      m_data = pend_data;
      m_err  = pend_err;
      m_zero = (pend_data == 32'd0);
      if (pend_owner == 0) e_r0 = 1'b1; else e_r1 = 1'b1;
    end
    w = -1;
    if (!rst && age >= 3) begin
      if (rv[0] && rv[1]) w = RR ? pref : 0;
      else if (rv[0])     w = 0;
      else if (rv[1])     w = 1;
    end
    chk("ack0", ack0, (w == 0));
    chk("ack1", ack1, (w == 1));
    chk("resp0_valid", resp0_valid, e_r0);
    chk("resp1_valid", resp1_valid, e_r1);
    chk("busy", busy, e_busy);
    chk("resp_data", resp_data, m_data);
    chk("resp_zero", resp_zero, m_zero);
    chk("resp_err", resp_err, m_err);
    s_ack0 = ack0; s_ack1 = ack1; s_r0 = resp0_valid; s_r1 = resp1_valid;
    s_data = resp_data; s_zero = resp_zero; s_err = resp_err; s_busy = busy;
    if (w >= 0) begin
      last_ack   = cyc;
      pend_owner = w;
      ref_op(rc[w], ra[w], rb[w], pend_data, pend_err);
      pref = (w == 0) ? 1 : 0;
    end
    cur_grant = w;
    if (rst) begin
      last_ack = -100;
      m_data   = 32'd0;
      m_zero   = 1'b0;
      m_err    = 1'b0;
      pref     = 0;
    end
  endtask

  task automatic step();
    @(negedge clk);
    check_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic directed(input int n, input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] ed, input logic ez, input logic ee);
    int got;
    got = 0;
    rv[n] = 1'b1; rc[n] = c; ra[n] = a; rb[n] = b;
    for (int i = 0; i < 8 && got == 0; i++) begin
      step();
      if (cur_grant == n) got = 1;
    end
    chk("dir_ack_seen", got, 1);
    rv[n] = 1'b0;
    step();
    chk("dir_k1_no_resp", {s_r1, s_r0}, 2'b00);
    chk("dir_k1_busy", s_busy, 1'b1);
    step();
    chk("dir_k2_resp_valid", {s_r1, s_r0}, (n == 0) ? 2'b01 : 2'b10);
    chk("dir_k2_data", s_data, ed);
    chk("dir_k2_zero", s_zero, ez);
    chk("dir_k2_err", s_err, ee);
    chk("dir_model_pin", m_data, ed);
  endtask

  function automatic logic [3:0] pick_op();
    logic [3:0] ops [6];
    ops[0] = 4'b0000; ops[1] = 4'b0001; ops[2] = 4'b0010;
    ops[3] = 4'b0110; ops[4] = 4'b0111; ops[5] = 4'b1100;
    if ($urandom_range(0, 7) == 0) return 4'($urandom_range(0, 15));
    return ops[$urandom_range(0, 5)];
  endfunction

  function automatic logic [31:0] pick_val();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'($urandom_range(0, 3));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int g [$];
    for (int n = 0; n < 2; n++) begin
      rv[n] = 1'b0; rc[n] = 4'd0; ra[n] = 32'd0; rb[n] = 32'd0;
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    step();
    chk("reset_busy", s_busy, 1'b0);
    chk("reset_data", s_data, 32'd0);
    chk("reset_valids", {s_r1, s_r0, s_ack1, s_ack0}, 4'b0000);
    rst = 1'b0;

    directed(0, 4'b0010, 32'd5, 32'd7, 32'd12, 1'b0, 1'b0);
    directed(1, 4'b0110, 32'd9, 32'd9, 32'd0, 1'b1, 1'b0);
    directed(1, 4'b0110, 32'd0, 32'd1, 32'hFFFF_FFFF, 1'b0, 1'b0);
    directed(0, 4'b1111, 32'd3, 32'd4, 32'd0, 1'b1, 1'b1);
    directed(0, 4'b0111, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1, 1'b0);
    directed(0, 4'b0111, 32'd1, 32'd2, 32'd1, 1'b0, 1'b0);
    directed(1, 4'b1100, 32'hF0F0_0000, 32'h0000_0F0F, 32'h0F0F_F0F0, 1'b0, 1'b0);

    // Fresh reset so the round-robin pointer starts at requester 0.
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int n = 0; n < 2; n++) begin
      rv[n] = 1'b1; rc[n] = 4'b0010; ra[n] = 32'(n + 1); rb[n] = 32'd10;
    end
    for (int i = 0; i < 12; i++) begin
      step();
      if (cur_grant >= 0) g.push_back(cur_grant);
    end
    rv[0] = 1'b0; rv[1] = 1'b0;
    chk("conflict_grant_count", (g.size() >= 4), 1'b1);
    if (g.size() >= 4) begin
      for (int i = 0; i < 4; i++) chk("conflict_grant_order", g[i], RR ? (i % 2) : 0);
    end
    repeat (3) step();

    // Reset during EXEC aborts the response.
    rv[0] = 1'b1; rc[0] = 4'b0010; ra[0] = 32'd5; rb[0] = 32'd7;
    begin
      int got;
      got = 0;
      for (int i = 0; i < 8 && got == 0; i++) begin
        step();
        if (cur_grant == 0) got = 1;
      end
      chk("abort_ack_seen", got, 1);
    end
    rv[0] = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    chk("abort_no_resp", {s_r1, s_r0}, 2'b00);
    chk("abort_busy", s_busy, 1'b0);
    chk("abort_data", s_data, 32'd0);
    chk("abort_flags", {s_zero, s_err, s_ack1, s_ack0}, 4'b0000);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 1500; i++) begin
      step();
      for (int n = 0; n < 2; n++) begin
        if (cur_grant == n) rv[n] = 1'b0;
      end
      rst = ($urandom_range(0, 149) == 0);
      for (int n = 0; n < 2; n++) begin
        if (!rv[n] && $urandom_range(0, 2) == 0) begin
          rv[n] = 1'b1;
          rc[n] = pick_op();
          ra[n] = pick_val();
          rb[n] = pick_val();
        end
      end
    end
    rst = 1'b0;
    rv[0] = 1'b0;
    rv[1] = 1'b0;
    repeat (4) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
